// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
package program_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddrH,
    StAddrL,
    StCntH,
    StCntL,
    StData,
    StWr,
    StCsum
  } state_e;

  localparam logic [7:0] HdrDefault = 8'hA5;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrCsum    = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;

endpackage

// File: rtl/program_loader_timeout.sv
// Inter-byte idle timer: reloads on clear, counts down while running, flags the TIMEOUT-th idle cycle.
module program_loader_timeout #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_clear) begin
      r_cnt <= CW'(TIMEOUT);
    end else if (i_run && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Reaching 1 while running means TIMEOUT idle cycles have elapsed since the last reload.
  assign o_expire = i_run && !i_clear && (r_cnt == CW'(1));

endmodule

// File: rtl/program_loader.sv
// Framed byte-stream loader: assembles instruction words and writes them into program memory.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned IA_W    = 16,
  parameter int unsigned ID_W    = 24,
  parameter logic [7:0]  HDR     = HdrDefault,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [7:0]      i_rx_data,
  input  logic            i_rx_valid,
  output logic            o_rx_ready,
  output logic [IA_W-1:0] o_a,
  output logic            o_we,
  output logic [ID_W-1:0] o_di,
  output logic            o_cpu_hold,
  output logic            o_done,
  output logic            o_err,
  output logic [1:0]      o_err_code
);

  localparam int unsigned BPW = ID_W / 8;
  localparam int unsigned BW  = (BPW > 1) ? $clog2(BPW) : 1;

  state_e r_state, w_state_next;

  logic [IA_W-1:0] r_addr, r_a;
  logic [ID_W-1:0] r_word, r_di;
  logic [15:0]     r_rem;
  logic [7:0]      r_addr_h, r_cnt_h, r_sum;
  logic [BW-1:0]   r_bidx;
  logic [1:0]      r_err_code;
  logic            r_started, r_done, r_err;

  logic            w_accept, w_expire, w_run, w_clear, w_last_byte;
  logic [7:0]      w_sum_next;
  logic [ID_W-1:0] w_word_next;

  assign w_accept    = i_rx_valid && o_rx_ready;
  assign w_sum_next  = r_sum + i_rx_data;
  assign w_word_next = (r_word << 8) | ID_W'(i_rx_data);
  assign w_last_byte = (r_bidx == BW'(BPW - 1));
  assign w_run       = (r_state != StIdle) && (r_state != StWr);
  assign w_clear     = w_accept || (r_state == StIdle);

  program_loader_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_clear),
    .i_run    (w_run),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (w_expire) begin
      w_state_next = StIdle;
    end else begin
      unique case (r_state)
        StIdle:  if (w_accept && (i_rx_data == HDR)) w_state_next = StAddrH;
        StAddrH: if (w_accept) w_state_next = StAddrL;
        StAddrL: if (w_accept) w_state_next = StCntH;
        StCntH:  if (w_accept) w_state_next = StCntL;
        StCntL:  if (w_accept) w_state_next = ({r_cnt_h, i_rx_data} == 16'd0) ? StCsum : StData;
        StData:  if (w_accept && w_last_byte) w_state_next = StWr;
        StWr:    w_state_next = (r_rem == 16'd1) ? StCsum : StData;
        StCsum:  if (w_accept) w_state_next = StIdle;
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_started  <= 1'b0;
      r_addr     <= '0;
      r_a        <= '0;
      r_word     <= '0;
      r_di       <= '0;
      r_rem      <= '0;
      r_addr_h   <= '0;
      r_cnt_h    <= '0;
      r_sum      <= '0;
      r_bidx     <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ErrNone;
    end else begin
      r_started <= 1'b1;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      if (w_accept) begin
        r_sum <= (r_state == StIdle) ? 8'd0 : w_sum_next;
      end
      if (w_expire) begin
        r_err      <= 1'b1;
        r_err_code <= ErrTimeout;
      end else begin
        case (r_state)
          StAddrH: if (w_accept) r_addr_h <= i_rx_data;
          StAddrL: if (w_accept) r_addr <= IA_W'({r_addr_h, i_rx_data});
          StCntH:  if (w_accept) r_cnt_h <= i_rx_data;
          StCntL: begin
            if (w_accept) begin
              r_rem  <= {r_cnt_h, i_rx_data};
              r_bidx <= '0;
            end
          end
          StData: begin
            if (w_accept) begin
              r_word <= w_word_next;
              if (w_last_byte) begin
                // Capture the write port here so A/DI stay put after the address advances.
                r_a    <= r_addr;
                r_di   <= w_word_next;
                r_bidx <= '0;
              end else begin
                r_bidx <= r_bidx + BW'(1);
              end
            end
          end
          StWr: begin
            r_addr <= r_addr + IA_W'(1);
            r_rem  <= r_rem - 16'd1;
          end
          StCsum: begin
            if (w_accept) begin
              if (w_sum_next == 8'd0) begin
                r_done     <= 1'b1;
                r_err_code <= ErrNone;
              end else begin
                r_err      <= 1'b1;
                r_err_code <= ErrCsum;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_rx_ready = r_started && (r_state != StWr);
  assign o_we       = (r_state == StWr);
  assign o_a        = r_a;
  assign o_di       = r_di;
  assign o_cpu_hold = (r_state != StIdle);
  assign o_done     = r_done;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes/completions queued at stimulus time.
module tb_program_loader;

  localparam int unsigned TO = 40;

  typedef struct packed {
    logic [1:0]  kind;  // 1 write, 2 done, 3 err
    logic [1:0]  code;
    logic [15:0] addr;
    logic [23:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, we, cpu_hold, done, err;
  logic [15:0] a;
  logic [23:0] di;
  logic [1:0]  err_code;

  int   n_vec = 0;
  int   n_miss = 0;
  ev_t  exp_q[$];

  program_loader #(
    .IA_W    (16),
    .ID_W    (24),
    .HDR     (8'hA5),
    .TIMEOUT (TO)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx_data  (rx_data),
    .i_rx_valid (rx_valid),
    .o_rx_ready (rx_ready),
    .o_a        (a),
    .o_we       (we),
    .o_di       (di),
    .o_cpu_hold (cpu_hold),
    .o_done     (done),
    .o_err      (err),
    .o_err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push_we(input logic [15:0] addr, input logic [23:0] data);
    ev_t e;
    e = '{kind: 2'd1, code: 2'd0, addr: addr, data: data};
    exp_q.push_back(e);
  endtask

  task automatic push_end(input logic [1:0] kind, input logic [1:0] code);
    ev_t e;
    e = '{kind: kind, code: code, addr: 16'h0, data: 24'h0};
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && (we || done || err)) begin
      ev_t got, exp;
      got.kind = we ? 2'd1 : (done ? 2'd2 : 2'd3);
      got.code = (done || err) ? err_code : 2'd0;
      got.addr = we ? a : 16'h0;
      got.data = we ? di : 24'h0;
      if (done && err) chk("done_err_together", 1, 0);
      if (done || err) chk("hold_at_end", cpu_hold, 0);
      if (exp_q.size() == 0) begin
        chk("unexpected_event", got, 0);
      end else begin
        exp = exp_q.pop_front();
        chk("event", got, exp);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    bit ok;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    ok = 0;
    for (int t = 0; t < 10; t++) begin
      if (rx_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) chk("rx_ready_wait", rx_ready, 1);
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic frame(input logic [15:0] addr, input int n, input logic [23:0] w0,
                       input logic [23:0] w1, input logic [7:0] bad);
    logic [7:0]  s, b;
    logic [15:0] ad, cnt;
    logic [23:0] w;
    s   = 8'h00;
    ad  = addr;
    cnt = 16'(n);
    for (int i = 0; i < n; i++) begin
      push_we(ad, (i == 0) ? w0 : w1);
      ad = ad + 16'd1;
    end
    if (bad == 8'h00) push_end(2'd2, 2'd0);
    else push_end(2'd3, 2'd1);
    send(8'hA5);
    b = addr[15:8]; s = s + b; send(b);
    b = addr[7:0];  s = s + b; send(b);
    b = cnt[15:8];  s = s + b; send(b);
    b = cnt[7:0];   s = s + b; send(b);
    for (int i = 0; i < n; i++) begin
      w = (i == 0) ? w0 : w1;
      for (int k = 2; k >= 0; k--) begin
        b = w[8*k +: 8];
        s = s + b;
        send(b);
      end
    end
    send(8'(8'h00 - s) + bad);
  endtask

  task automatic drain(input int budget, input string tag);
    for (int t = 0; t < budget && exp_q.size() != 0; t++) @(negedge clk);
    if (exp_q.size() != 0) chk(tag, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, rx_ready, 0);
    chk({tag, "_we"}, we, 0);
    chk({tag, "_hold"}, cpu_hold, 0);
    chk({tag, "_a"}, a, 0);
    chk({tag, "_di"}, di, 0);
    chk({tag, "_flags"}, {done, err, err_code}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    #1 chk("ready_before_edge", rx_ready, 0);
    @(posedge clk);
    #1 chk("ready_after_edge", rx_ready, 1);

    // Good two-word frame; CSUM works out to 0xEB
    frame(16'h0010, 2, 24'h123456, 24'hABCDEF, 8'h00);
    drain(100, "good_drain");

    // Same frame with CSUM 0xEC
    frame(16'h0010, 2, 24'h123456, 24'hABCDEF, 8'h01);
    drain(100, "csum_drain");
    chk("err_code_holds", err_code, 1);

    // Address wrap
    frame(16'hFFFF, 2, 24'h0A0B0C, 24'hF0E1D2, 8'h00);
    drain(100, "wrap_drain");

    // Garbage then empty frame
    send(8'h00);
    send(8'h37);
    chk("hold_garbage", cpu_hold, 0);
    push_end(2'd2, 2'd0);
    send(8'hA5);
    chk("hold_after_hdr", cpu_hold, 1);
    repeat (5) send(8'h00);
    drain(100, "empty_drain");

    // Timeout after the address bytes
    push_end(2'd3, 2'd2);
    send(8'hA5);
    send(8'h00);
    send(8'h10);
    repeat (5) @(negedge clk);
    chk("ready_during_idle", rx_ready, 1);
    chk("hold_during_idle", cpu_hold, 1);
    drain(TO + 50, "timeout_drain");
    chk("ready_after_timeout", rx_ready, 1);
    frame(16'h0100, 1, 24'h5A5A5A, 24'h000000, 8'h00);
    drain(100, "post_timeout_drain");

    // Reset after two of three data bytes
    send(8'hA5);
    send(8'h00);
    send(8'h20);
    send(8'h00);
    send(8'h01);
    send(8'h11);
    send(8'h22);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_midrst", rx_ready, 1);
    chk("queue_after_midrst", exp_q.size(), 0);
    frame(16'h0020, 2, 24'h112233, 24'h445566, 8'h00);
    drain(100, "post_rst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Byte-stream program loader for the PLC CPU. It receives framed program images from a host byte link, such as a UART receiver, and assembles them into ID_W-bit instruction words. It drives the write port of program_word_memory (A/WE/DI) and holds the CPU off the memory while a frame is in progress. It is the writer counterpart to the CPU's instruction fetch, which is the reader of that memory.

## Interface
- IA_W, 16, program memory address width
- ID_W, 24, instruction word width; must be a multiple of 8; BPW = ID_W/8 bytes per word
- HDR, 8'hA5, frame start byte
- TIMEOUT, 50000, maximum idle cycles between bytes inside a frame
- CLK  in  1  clock; all state changes on rising edge
- RST_N  in  1  asynchronous, active-low reset
- RX_DATA  in  8  incoming byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  loader accepts a byte; a transfer happens when RX_VALID & RX_READY at a rising edge
- A  out  IA_W  memory write address
- WE  out  1  memory write enable, single-cycle pulse
- DI  out  ID_W  memory write data
- CPU_HOLD  out  1  high while a frame is in progress (the BUSY condition)
- DONE  out  1  one-cycle pulse: frame completed with a good checksum
- ERR  out  1  one-cycle pulse: frame aborted
- ERR_CODE  out  2  last error cause: 0 none, 1 checksum, 2 timeout; holds until the next ERR or DONE (DONE clears it to 0)

## Operation
- Frame layout: HDR, ADDR_H, ADDR_L, CNT_H, CNT_L, then CNT words of BPW bytes each (MSB first), then CSUM.
- Checksum rule: the 8-bit sum of all bytes after HDR, CSUM included, must equal 0 mod 256.
- States and transitions:
  - IDLE: any byte other than HDR is accepted and discarded; HDR moves to ADDR_H.
  - ADDR_H → ADDR_L → CNT_H → CNT_L, one byte each.
  - CNT_L: if CNT = 0, go to CSUM; otherwise go to DATA.
  - DATA: shifts bytes into the word register. After byte BPW-1, go to WR.
  - WR: lasts one cycle. WE=1, A=current address, DI=assembled word, RX_READY=0. At its end, address += 1 (wraps mod 2^IA_W, no error) and remaining -= 1. If remaining = 0, go to CSUM; otherwise go to DATA.
  - CSUM: if the sum is 0, pulse DONE; otherwise pulse ERR with code 1. Either way, return to IDLE.
- Words already written are not rolled back on an error.
- CNT is 16-bit. CNT > 2^IA_W simply wraps the address and overwrites earlier words.
- A HDR byte inside a frame is treated as data, never as a resync.
- Timeout: the counter resets on every accepted byte and runs in all non-IDLE states except WR. When it reaches TIMEOUT, pulse ERR with code 2 and return to IDLE.
- RX_READY is 1 in every state except WR and reset.
- CPU_HOLD is 1 in all states other than IDLE.

## Timing
- Reset values: RX_READY=0, A=0, WE=0, DI=0, CPU_HOLD=0, DONE=0, ERR=0, ERR_CODE=0, state=IDLE.
- RX_READY rises on the first clock edge after RST_N deasserts.
- Asserting RST_N mid-frame aborts immediately. No ERR pulse is generated and no write occurs.
- WE goes high in the cycle after the last byte of a word is accepted, and lasts exactly one cycle.
- Memory write latency is one cycle from the last byte, so the written word is readable on the following edge.
- Back-to-back throughput is BPW+1 cycles per word.
- DONE and ERR pulse in the cycle after CSUM is accepted or the timeout fires. CPU_HOLD falls in that same cycle.
- DONE and ERR are never asserted together.
- A and DI hold their last written values while WE=0.

## Structure
- Shared include (alongside mplc_logic_il.v), named program_loader_defs.v, holds:
  - HDR default
  - ERR_CODE values
  - state encodings
- Sub-module program_loader_timeout: a loadable down-counter with clear and expire outputs.
- All other logic, including the FSM, shift register, address/count counters and checksum accumulator, lives in program_loader.

## Test plan
- Good frame: A5 00 10 00 02 12 34 56 AB CD EF EB → WE at A=0x0010 with DI=0x123456, then at A=0x0011 with DI=0xABCDEF, then a DONE pulse and ERR_CODE=0.
- Same frame with CSUM=0xEC → both words are written, then ERR pulses with ERR_CODE=1 and DONE stays 0.
- Address wrap: A5 FF FF 00 02 plus two words and a correct CSUM → writes at 0xFFFF then 0x0000, then DONE.
- Leading garbage then an empty frame: 00 37 A5 00 00 00 00 00 → no WE, DONE pulses, CPU_HOLD high only from HDR until DONE.
- Timeout: A5 00 10 then RX_VALID held low for TIMEOUT cycles → ERR with ERR_CODE=2, RX_READY stays 1, the next HDR starts a new frame.
- Reset mid-word: assert RST_N after 2 of 3 data bytes → all outputs return to reset values, no WE, no ERR; the next complete frame loads correctly.
